// File: rtl/jesd204_tx_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jesd204_tx_link_ctrl
// Brief    : JESD204B TX link bring-up sequencer. It drives the PHY reset,
//            aligns the local multiframe counter to SYSREF and steps the
//            datapath through CGS -> ILAS -> DATA under SYNC_n control.
// Options  : define SYSREF_ONESHOT_EN to make the LMFC counter ignore SYSREF
//            edges after the first one has moved the FSM out of SYSREF_WAIT.
// Revision : 1.0 - initial release
// ============================================================================
module jesd204_tx_link_ctrl #(
  parameter int LMFC_PERIOD   = 8,
  parameter int RST_CYCLES    = 16,
  parameter int TIMEOUT       = 65535,
  parameter int ILAS_MF       = 4,
  parameter int RESYNC_CYCLES = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           enable,
  input  logic                                           sync_n,
  input  logic                                           sysref,
  input  logic                                           phy_rst_done,
  output logic                                           phy_rst,
  output logic                                           lmfc_start,
  output logic                                           cgs,
  output logic                                           ilas,
  output logic [(ILAS_MF > 1 ? $clog2(ILAS_MF) : 1)-1:0] ilas_mf_idx,
  output logic                                           data_en,
  output logic                                           rdy,
  output logic                                           timeout_err,
  output logic [7:0]                                     sync_err_cnt,
  output logic [2:0]                                     state
);

  localparam int LMFC_W  = $clog2(LMFC_PERIOD);
  localparam int IDX_W   = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
  localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SL_W    = $clog2(RESYNC_CYCLES + 1);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_PHY_RST     = 3'd1;
  localparam logic [2:0] ST_PHY_WAIT    = 3'd2;
  localparam logic [2:0] ST_SYSREF_WAIT = 3'd3;
  localparam logic [2:0] ST_CGS         = 3'd4;
  localparam logic [2:0] ST_ILAS        = 3'd5;
  localparam logic [2:0] ST_DATA        = 3'd6;
  localparam logic [2:0] ST_FAULT       = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [LMFC_W-1:0] lmfc_cnt_q, lmfc_cnt_d;
  logic              sysref_prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  mf_idx_q, mf_idx_d;
  logic [SL_W-1:0]   sync_low_q, sync_low_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic              rdy_q;

  logic sysref_edge, realign_en, lmfc_last, in_mon, resync, err_pulse;

  assign sysref_edge = sysref & ~sysref_prev_q;
  assign lmfc_last   = (lmfc_cnt_q == LMFC_W'(LMFC_PERIOD - 1));
  assign in_mon      = (state_q == ST_ILAS) || (state_q == ST_DATA);
  assign resync      = in_mon && !sync_n && (sync_low_q == SL_W'(RESYNC_CYCLES - 1));
  assign err_pulse   = in_mon && sync_n && (sync_low_q != '0);

`ifdef SYSREF_ONESHOT_EN
  logic sysref_lock_q, sysref_lock_d;

  // Lock out realignment once SYSREF_WAIT is left for CGS; unlock on re-entry.
  always_comb begin
    sysref_lock_d = sysref_lock_q;
    if (state_q == ST_SYSREF_WAIT) sysref_lock_d = (state_d == ST_CGS);
  end

  // Oneshot lock register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sysref_lock_q <= 1'b0;
    else        sysref_lock_q <= sysref_lock_d;
  end

  assign realign_en = ~sysref_lock_q;
`else
  assign realign_en = 1'b1;
`endif

  // LMFC counter: free-running modulo LMFC_PERIOD, zeroed by a SYSREF edge.
  always_comb begin
    lmfc_cnt_d = lmfc_cnt_q + 1'b1;
    if ((sysref_edge && realign_en) || lmfc_last) lmfc_cnt_d = '0;
  end

  // Next-state logic; ENABLE low wins, then PHY loss, then SYNC/LMFC events.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:        state_d = ST_PHY_RST;
        ST_PHY_RST:     if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_PHY_WAIT;
        ST_PHY_WAIT: begin
          if (phy_rst_done)                        state_d = ST_SYSREF_WAIT;
          else if (cnt_q == CNT_W'(TIMEOUT - 1))   state_d = ST_FAULT;
        end
        ST_SYSREF_WAIT: begin
          if (!phy_rst_done)    state_d = ST_PHY_RST;
          else if (sysref_edge) state_d = ST_CGS;
        end
        ST_CGS: begin
          if (!phy_rst_done)            state_d = ST_PHY_RST;
          else if (lmfc_last && sync_n) state_d = ST_ILAS;
        end
        ST_ILAS: begin
          if (!phy_rst_done) state_d = ST_PHY_RST;
          else if (resync)   state_d = ST_CGS;
          else if (lmfc_last && (mf_idx_q == IDX_W'(ILAS_MF - 1))) state_d = ST_DATA;
        end
        ST_DATA: begin
          if (!phy_rst_done) state_d = ST_PHY_RST;
          else if (resync)   state_d = ST_CGS;
        end
        default:            state_d = state_q;
      endcase
    end
  end

  // Reset-hold / PHY-wait cycle counter, restarted on every state change.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == ST_PHY_RST) || (state_q == ST_PHY_WAIT)))
      cnt_d = cnt_q + 1'b1;
  end

  // ILAS multiframe index advances at each multiframe end while in ILAS.
  always_comb begin
    mf_idx_d = '0;
    if ((state_q == ST_ILAS) && (state_d == ST_ILAS))
      mf_idx_d = lmfc_last ? mf_idx_q + 1'b1 : mf_idx_q;
  end

  // SYNC_n low-run length and sticky error/timeout flags.
  always_comb begin
    sync_low_d    = '0;
    err_cnt_d     = err_cnt_q;
    timeout_err_d = timeout_err_q;
    if (in_mon && !sync_n) sync_low_d = sync_low_q + 1'b1;
    if (state_d == ST_IDLE) begin
      err_cnt_d     = '0;
      timeout_err_d = 1'b0;
    end else begin
      if (err_pulse && (err_cnt_q != 8'd255))            err_cnt_d     = err_cnt_q + 8'd1;
      if ((state_q == ST_PHY_WAIT) && (state_d == ST_FAULT)) timeout_err_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      lmfc_cnt_q    <= '0;
      sysref_prev_q <= 1'b0;
      cnt_q         <= '0;
      mf_idx_q      <= '0;
      sync_low_q    <= '0;
      err_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      rdy_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      lmfc_cnt_q    <= lmfc_cnt_d;
      sysref_prev_q <= sysref;
      cnt_q         <= cnt_d;
      mf_idx_q      <= mf_idx_d;
      sync_low_q    <= sync_low_d;
      err_cnt_q     <= err_cnt_d;
      timeout_err_q <= timeout_err_d;
      rdy_q         <= data_en;
    end
  end

  assign phy_rst      = (state_q == ST_IDLE) || (state_q == ST_PHY_RST) || (state_q == ST_FAULT);
  assign lmfc_start   = (lmfc_cnt_q == '0);
  assign cgs          = (state_q == ST_CGS);
  assign ilas         = (state_q == ST_ILAS);
  assign data_en      = (state_q == ST_DATA);
  assign rdy          = rdy_q;
  assign ilas_mf_idx  = mf_idx_q;
  assign timeout_err  = timeout_err_q;
  assign sync_err_cnt = err_cnt_q;
  assign state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_jesd204_tx_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jesd204_tx_link_ctrl
// Brief    : Directed bench for jesd204_tx_link_ctrl with a queue scoreboard
//            and a reference LMFC counter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jesd204_tx_link_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       sync_n = 1'b0;
  logic       sysref = 1'b0;
  logic       phy_rst_done = 1'b0;
  logic       phy_rst, lmfc_start, cgs, ilas, data_en, rdy, timeout_err;
  logic [1:0] ilas_mf_idx;
  logic [7:0] sync_err_cnt;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  string       tq[$];
  logic [31:0] vq[$];

  // Reference LMFC counter (period 8)
  logic [2:0] m_cnt;
  logic       m_prev;
  bit         m_realign = 1'b1;

  jesd204_tx_link_ctrl #(
    .LMFC_PERIOD(8), .RST_CYCLES(16), .TIMEOUT(100), .ILAS_MF(4), .RESYNC_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sync_n(sync_n), .sysref(sysref),
    .phy_rst_done(phy_rst_done), .phy_rst(phy_rst), .lmfc_start(lmfc_start),
    .cgs(cgs), .ilas(ilas), .ilas_mf_idx(ilas_mf_idx), .data_en(data_en), .rdy(rdy),
    .timeout_err(timeout_err), .sync_err_cnt(sync_err_cnt), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 3'd0;
      m_prev <= 1'b0;
    end else begin
      m_prev <= sysref;
      if (sysref && !m_prev && m_realign) m_cnt <= 3'd0;
      else                                m_cnt <= m_cnt + 3'd1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    tq.push_back(tag);
    vq.push_back(v);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    string       tag;
    logic [31:0] v;
    vectors++;
    if (vq.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      tag = tq.pop_front();
      v   = vq.pop_front();
      assert (obs === v) else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, v);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] v);
    push(tag, v);
    pop_chk(obs);
  endtask

  task automatic err_pulse();
    sync_n = 1'b0;
    tick(2);
    sync_n = 1'b1;
    tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_state", state, 0);
    chk("rst_phy_rst", phy_rst, 1);
    chk("rst_lmfc_start", lmfc_start, 1);
    chk("rst_flags", {cgs, ilas, data_en, rdy, timeout_err}, 0);
    chk("rst_err_cnt", sync_err_cnt, 0);
    chk("rst_mf_idx", ilas_mf_idx, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Nominal bring-up
    enable = 1'b1;
    push("enable_to_phy_rst", 1);
    tick(1);
    pop_chk(state);
    tick(15);
    chk("phy_rst_held_state", state, 1);
    chk("phy_rst_held_out", phy_rst, 1);
    tick(1);
    chk("phy_wait_state", state, 2);
    chk("phy_wait_rst_low", phy_rst, 0);
    tick(3);
    phy_rst_done = 1'b1;
    push("done_to_sysref_wait", 3);
    tick(1);
    pop_chk(state);
    tick(2);
    sysref = 1'b1;
    push("sysref_to_cgs", 4);
    push("cgs_out", 1);
    push("sysref_lmfc_start", 1);
    tick(1);
    pop_chk(state);
    pop_chk(cgs);
    pop_chk(lmfc_start);
    sysref = 1'b0;
    tick(3);
    sync_n = 1'b1;
    tick(4);
    chk("cgs_hold_mid_mf", state, 4);
    tick(1);
    chk("ilas_start_state", state, 5);
    chk("ilas_out", {cgs, ilas}, 2'b01);
    chk("ilas_idx0", ilas_mf_idx, 0);
    chk("ilas_lmfc_start", lmfc_start, 1);
    tick(8);
    chk("ilas_idx1", ilas_mf_idx, 1);
    tick(23);
    chk("ilas_last_state", state, 5);
    chk("ilas_last_idx", ilas_mf_idx, 3);
    chk("ilas_last_data_en", data_en, 0);
    tick(1);
    chk("data_state", state, 6);
    chk("data_en_on", data_en, 1);
    chk("rdy_lag", rdy, 0);
    tick(1);
    chk("rdy_on", rdy, 1);

    // Short SYNC_n pulses
    err_pulse();
    chk("err_cnt_1", sync_err_cnt, 1);
    err_pulse();
    err_pulse();
    chk("err_cnt_3", sync_err_cnt, 3);
    chk("err_stay_data", state, 6);

    // SYSREF edge at counter 5 while in DATA
    for (int i = 0; i < 16 && m_cnt != 3'd5; i++) tick(1);
    chk("pre_realign_lmfc", lmfc_start, 0);
    sysref = 1'b1;
`ifdef SYSREF_ONESHOT_EN
    m_realign = 1'b0;
    push("realign_next", 0);
    push("realign_plus2", 1);
`else
    push("realign_next", 1);
    push("realign_plus2", 0);
`endif
    tick(1);
    sysref = 1'b0;
    pop_chk(lmfc_start);
    tick(2);
    pop_chk(lmfc_start);
    chk("realign_state", state, 6);

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) err_pulse();
    chk("err_cnt_sat", sync_err_cnt, 255);
    chk("err_sat_state", state, 6);

    // Resync request
    sync_n = 1'b0;
    tick(3);
    chk("resync_3_low", state, 6);
    tick(1);
    chk("resync_cgs", state, 4);
    chk("resync_data_en", data_en, 0);
    chk("resync_err_kept", sync_err_cnt, 255);
    tick(1);
    chk("resync_rdy", rdy, 0);
    chk("resync_stay_cgs", state, 4);
    sync_n = 1'b1;
    for (int i = 0; i < 16 && m_cnt != 3'd7; i++) tick(1);
    chk("resync_wait_bound", state, 4);
    tick(1);
    chk("resync_ilas", state, 5);
    chk("resync_idx", ilas_mf_idx, 0);
    chk("resync_ilas_lmfc", lmfc_start, 1);

    // PHY loss during ILAS
    tick(3);
    phy_rst_done = 1'b0;
    tick(1);
    chk("phy_loss_state", state, 1);
    chk("phy_loss_rst", phy_rst, 1);
    chk("phy_loss_ilas", ilas, 0);
    tick(15);
    chk("phy_loss_held", state, 1);
    tick(1);
    chk("phy_loss_wait", state, 2);
    chk("phy_loss_rst_low", phy_rst, 0);

    // PHY timeout
    tick(99);
    chk("timeout_pre_state", state, 2);
    chk("timeout_pre_flag", timeout_err, 0);
    tick(1);
    chk("timeout_fault", state, 7);
    chk("timeout_flag", timeout_err, 1);
    chk("timeout_phy_rst", phy_rst, 1);
    tick(5);
    chk("fault_hold", state, 7);
    enable = 1'b0;
    tick(1);
    chk("disable_idle", state, 0);
    chk("idle_clear_timeout", timeout_err, 0);
    chk("idle_clear_err", sync_err_cnt, 0);

    // DONE on the timeout cycle wins
    enable = 1'b1;
    tick(17);
    chk("win_phy_wait", state, 2);
    tick(99);
    phy_rst_done = 1'b1;
    tick(1);
    chk("done_wins_timeout", state, 3);

    // Asynchronous reset mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_phy_rst", phy_rst, 1);
    chk("async_rst_lmfc", lmfc_start, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
